// File: rtl/riscv_alu.sv
// RV32I integer ALU: arithmetic/logic/shift/set-less-than on Result, branch compare on Flag,
// sticky IllegalOp for undefined opcodes. Define ALU_OUT_REG_EN to register Result/Flag (1-cycle latency).
module riscv_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ALUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Result,
    output logic        Flag,
    output logic        IllegalOp
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b00001;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b01101;
    localparam logic [4:0] OP_SLTS = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;
    localparam logic [4:0] OP_LTS  = 5'b11100;
    localparam logic [4:0] OP_LTU  = 5'b11110;
    localparam logic [4:0] OP_GES  = 5'b11101;
    localparam logic [4:0] OP_GEU  = 5'b11111;
    localparam logic [4:0] OP_EQ   = 5'b11000;
    localparam logic [4:0] OP_NE   = 5'b11001;

    logic [31:0] result_d;
    logic        flag_d;
    logic        legal_op;
    logic        illegal_d;
    logic        illegal_q;
    logic        lt_s;
    logic        lt_u;
    logic [4:0]  shamt;

    assign lt_s  = $signed(A) < $signed(B);
    assign lt_u  = A < B;
    assign shamt = B[4:0];

    always_comb begin
        result_d = '0;
        flag_d   = 1'b0;
        legal_op = 1'b1;
        case (ALUOp)
            OP_ADD:  result_d = A + B;
            OP_SUB:  result_d = A - B;
            OP_XOR:  result_d = A ^ B;
            OP_OR:   result_d = A | B;
            OP_AND:  result_d = A & B;
            OP_SLL:  result_d = A << shamt;
            OP_SRL:  result_d = A >> shamt;
            OP_SRA:  result_d = $unsigned($signed(A) >>> shamt);
            OP_SLTS: result_d = {31'b0, lt_s};
            OP_SLTU: result_d = {31'b0, lt_u};
            OP_LTS:  flag_d   = lt_s;
            OP_LTU:  flag_d   = lt_u;
            OP_GES:  flag_d   = ~lt_s;
            OP_GEU:  flag_d   = ~lt_u;
            OP_EQ:   flag_d   = (A == B);
            OP_NE:   flag_d   = (A != B);
            default: legal_op = 1'b0;
        endcase
    end

    // Once set, only reset clears the error indication.
    assign illegal_d = illegal_q | ~legal_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign IllegalOp = illegal_q;

`ifdef ALU_OUT_REG_EN
    logic [31:0] result_q;
    logic        flag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign Result = result_q;
    assign Flag   = flag_q;
`else
    assign Result = result_d;
    assign Flag   = flag_d;
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// Scoreboard bench for riscv_alu: driver pushes expected responses, a negedge monitor pops and compares.
module tb_riscv_alu;

`ifdef ALU_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ALUOp = 5'b00000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Result;
    logic        Flag;
    logic        IllegalOp;

    riscv_alu dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .A(A), .B(B),
        .Result(Result), .Flag(Flag), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          issue_cyc;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        flag;
        logic        ill;
    } txn_t;

    txn_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic sticky_model = 1'b0;

    logic [4:0] legal_ops [16] = '{5'b00000, 5'b01000, 5'b00100, 5'b00110, 5'b00111,
                                   5'b00001, 5'b00101, 5'b01101, 5'b00010, 5'b00011,
                                   5'b11100, 5'b11110, 5'b11101, 5'b11111, 5'b11000, 5'b11001};

    function automatic bit is_legal(input logic [4:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: plain arithmetic on the opcode table.
    function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic flag);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          sa = longint'(int'(a));
        longint          sb = longint'(int'(b));
        int              sh = int'(b % 32);
        longint unsigned p2 = 64'd1 << sh;
        res  = 32'd0;
        flag = 1'b0;
        case (op)
            5'b00000: res = 32'((ua + ub) % 64'h1_0000_0000);
            5'b01000: res = 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            5'b00100: res = a ^ b;
            5'b00110: res = a | b;
            5'b00111: res = a & b;
            5'b00001: res = 32'((ua * p2) % 64'h1_0000_0000);
            5'b00101: res = 32'(ua / p2);
            5'b01101: res = 32'((sa - ((sa % longint'(p2) + longint'(p2)) % longint'(p2))) / longint'(p2));
            5'b00010: res = (sa < sb) ? 32'd1 : 32'd0;
            5'b00011: res = (ua < ub) ? 32'd1 : 32'd0;
            5'b11100: flag = (sa < sb);
            5'b11110: flag = (ua < ub);
            5'b11101: flag = (sa >= sb);
            5'b11111: flag = (ua >= ub);
            5'b11000: flag = (ua == ub);
            5'b11001: flag = (ua != ub);
            default: ;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one transaction just after a rising edge and push its expected response.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit use_const, input logic [31:0] c_res, input logic c_flag);
        txn_t t;
        logic [31:0] m_res;
        logic        m_flag;
        @(posedge clk);
        #1;
        ALUOp = op; A = a; B = b;
        ref_model(op, a, b, m_res, m_flag);
        t.issue_cyc = cyc;
        t.op = op; t.a = a; t.b = b;
        t.res  = use_const ? c_res : m_res;
        t.flag = use_const ? c_flag : m_flag;
        t.ill  = sticky_model;
        if (!is_legal(op)) sticky_model = 1'b1;
        if (LAT != 0) t.ill = sticky_model;
        q.push_back(t);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (q.size() > 0 && cyc >= q[0].issue_cyc + LAT) begin
            txn_t t;
            t = q.pop_front();
            check($sformatf("result op=%b a=%h b=%h", t.op, t.a, t.b), Result, t.res);
            check($sformatf("flag op=%b a=%h b=%h", t.op, t.a, t.b), {31'b0, Flag}, {31'b0, t.flag});
            check($sformatf("illegal op=%b", t.op), {31'b0, IllegalOp}, {31'b0, t.ill});
            $display("txn op=%b a=%h b=%h -> res=%h flag=%b ill=%b", t.op, t.a, t.b, Result, Flag, IllegalOp);
        end
    end

    task automatic drain();
        int budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
            q.delete();
        end
    endtask

    // Pulse reset between edges and check its immediate effect.
    task automatic mid_cycle_reset(input bool_hold_edge);
        @(negedge clk);
        #2;
        rst = 1'b1;
        sticky_model = 1'b0;
        #1;
        check("async rst illegal", {31'b0, IllegalOp}, 32'd0);
        if (LAT != 0) begin
            check("async rst result", Result, 32'd0);
            check("async rst flag", {31'b0, Flag}, 32'd0);
        end
        if (bool_hold_edge) begin
            ALUOp = 5'b10000;
            @(posedge clk);
            #1;
            check("rst wins over illegal", {31'b0, IllegalOp}, 32'd0);
            ALUOp = 5'b00000;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        flag;
    } dir_t;

    dir_t dirs [] = '{
        '{5'b00000, 32'd1, 32'd2, 32'd3, 1'b0},
        '{5'b00000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0},
        '{5'b01000, 32'd1, 32'd2, 32'hFFFFFFFF, 1'b0},
        '{5'b01000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0},
        '{5'b00100, 32'd1, 32'd3, 32'd2, 1'b0},
        '{5'b00110, 32'd1, 32'd3, 32'd3, 1'b0},
        '{5'b00111, 32'd1, 32'd3, 32'd1, 1'b0},
        '{5'b00001, 32'd3, 32'd2, 32'd12, 1'b0},
        '{5'b00101, 32'd3, 32'd2, 32'd0, 1'b0},
        '{5'b01101, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0},
        '{5'b01101, 32'd5, 32'd2, 32'd1, 1'b0},
        '{5'b00001, 32'd1, 32'd33, 32'd2, 1'b0},
        '{5'b00010, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0},
        '{5'b00011, 32'hFFFFFFFD, 32'd2, 32'd0, 1'b0},
        '{5'b11101, 32'd1, 32'hFFFFFFFD, 32'd0, 1'b1},
        '{5'b11101, 32'd1, 32'd3, 32'd0, 1'b0},
        '{5'b11110, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b0},
        '{5'b11110, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0, 1'b0},
        '{5'b11000, 32'd1, 32'd1, 32'd0, 1'b1},
        '{5'b11001, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1},
        '{5'b11100, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b1},
        '{5'b11111, 32'd3, 32'd3, 32'd0, 1'b1},
        '{5'b10000, 32'd7, 32'd9, 32'd0, 1'b0},
        '{5'b00000, 32'd1, 32'd2, 32'd3, 1'b0}
    };

    initial begin
        #1;
        check("reset illegal", {31'b0, IllegalOp}, 32'd0);
        if (LAT != 0) check("reset result", Result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (dirs[i]) issue(dirs[i].op, dirs[i].a, dirs[i].b, 1'b1, dirs[i].res, dirs[i].flag);
        drain();
        @(negedge clk);
        check("illegal sticky after ADD", {31'b0, IllegalOp}, 32'd1);
        mid_cycle_reset(1'b1);

        for (int blk = 0; blk < 6; blk++) begin
            for (int k = 0; k < 40; k++) begin
                logic [4:0]  op;
                logic [31:0] a;
                logic [31:0] b;
                if ($urandom_range(0, 39) == 0) op = 5'($urandom);
                else op = legal_ops[$urandom_range(0, 15)];
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(0, 63));
                issue(op, a, b, 1'b0, 32'd0, 1'b0);
            end
            drain();
            mid_cycle_reset(blk == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
